ahb_beat_serializer: RTL and testbench



---
 rtl/ahb_beat_serializer.sv | 149 ++++++++++++++
 tb/tb_ahb_beat_serializer.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_beat_serializer.sv
// ahb_beat_serializer: takes one IN_W-bit word per handshake and emits it as
// OUT_W-bit beats, least-significant slice first. Beats that run past IN_W
// are zero-filled. in_ready is combinational from out_ready, so back-to-back
// words stream without a bubble.
module ahb_beat_serializer #(
    parameter  int IN_W   = 32,
    parameter  int OUT_W  = 8,
    localparam int NBEATS = (IN_W + OUT_W - 1) / OUT_W,
    localparam int CNT_W  = ($clog2(NBEATS + 1) > 1) ? $clog2(NBEATS + 1) : 1
) (
    input  logic             HCLK,
    input  logic             HRESET,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_data,
    input  logic [CNT_W-1:0] in_len,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic [CNT_W-1:0] out_idx,
    output logic             out_last,
    output logic             busy
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_t;

    localparam int               PAD_W    = NBEATS * OUT_W;
    localparam logic [CNT_W-1:0] NBEATS_C = CNT_W'(NBEATS);
    localparam logic [CNT_W-1:0] ONE_C    = CNT_W'(1'b1);
    localparam logic [CNT_W-1:0] ZERO_C   = {CNT_W{1'b0}};

    // A length of zero, or one larger than the word holds, means "all beats".
    function automatic logic [CNT_W-1:0] clamp_len(input logic [CNT_W-1:0] len);
        if ((len == ZERO_C) || (len > NBEATS_C)) begin
            return NBEATS_C;
        end else begin
            return len;
        end
    endfunction

    // Select beat 'idx' of the word; bit positions at or above IN_W read as zero.
    function automatic logic [OUT_W-1:0] slice_beat(input logic [IN_W-1:0]  word,
                                                    input logic [CNT_W-1:0] idx);
        logic [PAD_W-1:0] pad;
        logic [OUT_W-1:0] res;
        pad            = {PAD_W{1'b0}};
        pad[IN_W-1:0]  = word;
        res            = {OUT_W{1'b0}};
        for (int b = 0; b < NBEATS; b++) begin
            if (idx == CNT_W'(b)) begin
                res = pad[b*OUT_W +: OUT_W];
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    state_t           state_q, state_d;
    logic [IN_W-1:0]  word_q,  word_d;
    logic [CNT_W-1:0] idx_q,   idx_d;
    logic [CNT_W-1:0] len_q,   len_d;

    logic             send_s;
    logic             last_s;
    logic             in_fire_s;
    logic             out_fire_s;

    assign send_s     = (state_q == ST_SEND);
    assign last_s     = send_s & (idx_q == (len_q - ONE_C));
    assign in_ready   = ~HRESET & (~send_s | (last_s & out_ready));
    assign in_fire_s  = in_valid & in_ready;
    assign out_fire_s = send_s & out_ready;

    assign out_valid  = send_s;
    assign out_last   = last_s;
    assign out_idx    = idx_q;
    assign busy       = send_s;

    // Beat data is forced to zero outside SEND so a stale word never leaks out.
    always_comb begin
        out_data = {OUT_W{1'b0}};
        if (send_s) begin
            out_data = slice_beat(word_q, idx_q);
        end else begin
            out_data = {OUT_W{1'b0}};
        end
    end

    // Next-state logic: load on input transfer, step idx on each output beat.
    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        idx_d   = idx_q;
        len_d   = len_q;
        case (state_q)
            ST_IDLE: begin
                if (in_fire_s) begin
                    state_d = ST_SEND;
                    word_d  = in_data;
                    idx_d   = ZERO_C;
                    len_d   = clamp_len(in_len);
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SEND: begin
                if (out_fire_s) begin
                    if (!last_s) begin
                        idx_d = idx_q + ONE_C;
                    end else if (in_fire_s) begin
                        state_d = ST_SEND;
                        word_d  = in_data;
                        idx_d   = ZERO_C;
                        len_d   = clamp_len(in_len);
                    end else begin
                        state_d = ST_IDLE;
                        idx_d   = ZERO_C;
                    end
                end else begin
                    state_d = ST_SEND;
                end
            end
            default: begin
                state_d = ST_IDLE;
                idx_d   = ZERO_C;
            end
        endcase
    end

    // State registers; reset discards any word in flight.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_q <= ST_IDLE;
            word_q  <= {IN_W{1'b0}};
            idx_q   <= ZERO_C;
            len_q   <= ZERO_C;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            idx_q   <= idx_d;
            len_q   <= len_d;
        end
    end

endmodule

// File: tb/tb_ahb_beat_serializer.sv
// Scoreboard bench: stimulus pushes hand-computed expected beats, per-DUT
// monitors pop and compare on every output transfer. Two instances cover
// the even (32/8) and zero-fill (20/8) geometries.
module tb_ahb_beat_serializer;

    logic        HCLK = 1'b0;
    logic        HRESET;

    logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_last, a_busy;
    logic [31:0] a_in_data;
    logic [2:0]  a_in_len, a_out_idx;
    logic [7:0]  a_out_data;

    logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_last, b_busy;
    logic [19:0] b_in_data;
    logic [1:0]  b_in_len, b_out_idx;
    logic [7:0]  b_out_data;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        logic [7:0] d;
        int         idx;
        bit         last;
        bit         cont;
    } exp_t;

    exp_t qa[$];
    exp_t qb[$];
    int   a_last_cyc = 0;
    int   b_last_cyc = 0;

    ahb_beat_serializer #(.IN_W(32), .OUT_W(8)) dut_a (
        .HCLK(HCLK), .HRESET(HRESET),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data), .in_len(a_in_len),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
        .out_idx(a_out_idx), .out_last(a_out_last), .busy(a_busy)
    );

    ahb_beat_serializer #(.IN_W(20), .OUT_W(8)) dut_b (
        .HCLK(HCLK), .HRESET(HRESET),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data), .in_len(b_in_len),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
        .out_idx(b_out_idx), .out_last(b_out_last), .busy(b_busy)
    );

    always #5 HCLK = ~HCLK;

    always @(posedge HCLK) cyc <= cyc + 1;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic void push_a(input logic [7:0] d, input int idx, input bit last, input bit cont);
        exp_t e;
        e.d = d; e.idx = idx; e.last = last; e.cont = cont;
        qa.push_back(e);
    endfunction

    function automatic void push_b(input logic [7:0] d, input int idx, input bit last, input bit cont);
        exp_t e;
        e.d = d; e.idx = idx; e.last = last; e.cont = cont;
        qb.push_back(e);
    endfunction

    // Monitor A: a beat seen valid&ready here transfers at the next rising edge.
    always @(negedge HCLK) begin
        if (!HRESET && a_out_valid && a_out_ready) begin
            if (qa.size() == 0) begin
                check("A.unexpected_beat", 32'(a_out_data), 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = qa.pop_front();
                check("A.data", 32'(a_out_data), 32'(e.d));
                check("A.idx",  32'(a_out_idx),  32'(e.idx));
                check("A.last", 32'(a_out_last), 32'(e.last));
                if (e.cont) check("A.no_gap_cycle", 32'(cyc), 32'(a_last_cyc + 1));
            end
            a_last_cyc = cyc;
        end
    end

    // Monitor B: same scheme for the zero-fill instance.
    always @(negedge HCLK) begin
        if (!HRESET && b_out_valid && b_out_ready) begin
            if (qb.size() == 0) begin
                check("B.unexpected_beat", 32'(b_out_data), 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = qb.pop_front();
                check("B.data", 32'(b_out_data), 32'(e.d));
                check("B.idx",  32'(b_out_idx),  32'(e.idx));
                check("B.last", 32'(b_out_last), 32'(e.last));
                if (e.cont) check("B.no_gap_cycle", 32'(cyc), 32'(b_last_cyc + 1));
            end
            b_last_cyc = cyc;
        end
    end

    // Offer a word on A; returns after the accepting edge with in_valid still high.
    task automatic offer_a(input logic [31:0] d, input logic [2:0] l, output int waited);
        bit acc;
        acc = 1'b0; waited = 0;
        a_in_data = d; a_in_len = l; a_in_valid = 1'b1;
        while (!acc && waited < 20) begin
            @(negedge HCLK);
            acc = a_in_ready;
            @(posedge HCLK); #1;
            waited++;
        end
        if (!acc) check("A.accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic offer_b(input logic [19:0] d, input logic [1:0] l, output int waited);
        bit acc;
        acc = 1'b0; waited = 0;
        b_in_data = d; b_in_len = l; b_in_valid = 1'b1;
        while (!acc && waited < 20) begin
            @(negedge HCLK);
            acc = b_in_ready;
            @(posedge HCLK); #1;
            waited++;
        end
        if (!acc) check("B.accept_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int w;
        HRESET = 1'b1;
        a_in_valid = 1'b0; a_in_data = 32'h0; a_in_len = 3'd0; a_out_ready = 1'b1;
        b_in_valid = 1'b0; b_in_data = 20'h0; b_in_len = 2'd0; b_out_ready = 1'b1;
        repeat (2) @(posedge HCLK);
        #1;
        check("rst.out_valid", 32'(a_out_valid), 32'd0);
        check("rst.out_last",  32'(a_out_last),  32'd0);
        check("rst.busy",      32'(a_busy),      32'd0);
        check("rst.out_data",  32'(a_out_data),  32'd0);
        check("rst.out_idx",   32'(a_out_idx),   32'd0);
        check("rst.in_ready",  32'(a_in_ready),  32'd0);
        check("rst.B.in_ready", 32'(b_in_ready), 32'd0);
        HRESET = 1'b0;
        #1;
        check("post_rst.in_ready",   32'(a_in_ready), 32'd1);
        check("post_rst.B.in_ready", 32'(b_in_ready), 32'd1);
        @(posedge HCLK); #1;

        // Basic serialize, in_len=0 means all 4 beats.
        push_a(8'hD4, 0, 1'b0, 1'b0);
        push_a(8'hC3, 1, 1'b0, 1'b1);
        push_a(8'hB2, 2, 1'b0, 1'b1);
        push_a(8'hA1, 3, 1'b1, 1'b1);
        offer_a(32'hA1B2_C3D4, 3'd0, w);
        a_in_valid = 1'b0;
        check("basic.latency_valid", 32'(a_out_valid), 32'd1);
        check("basic.latency_data",  32'(a_out_data),  32'hD4);
        repeat (4) @(posedge HCLK);
        #1;
        check("basic.idle_busy",     32'(a_busy),     32'd0);
        check("basic.idle_in_ready", 32'(a_in_ready), 32'd1);
        check("basic.idle_data",     32'(a_out_data), 32'd0);

        // Clamp on A: in_len=7 > 4 beats.
        push_a(8'h0D, 0, 1'b0, 1'b0);
        push_a(8'h0C, 1, 1'b0, 1'b1);
        push_a(8'h0B, 2, 1'b0, 1'b1);
        push_a(8'h0A, 3, 1'b1, 1'b1);
        offer_a(32'h0A0B_0C0D, 3'd7, w);
        a_in_valid = 1'b0;
        repeat (5) @(posedge HCLK);
        #1;

        // Zero-fill on the 20-bit instance; 3 is the widest length it can express.
        push_b(8'hCD, 0, 1'b0, 1'b0);
        push_b(8'hAB, 1, 1'b0, 1'b1);
        push_b(8'h0F, 2, 1'b1, 1'b1);
        offer_b(20'hFABCD, 2'd3, w);
        b_in_valid = 1'b0;
        repeat (3) @(posedge HCLK);
        #1;
        check("zfill.idle_busy", 32'(b_busy), 32'd0);

        // Backpressure at beat 1; a competing word must not be taken meanwhile.
        push_a(8'h44, 0, 1'b0, 1'b0);
        push_a(8'h33, 1, 1'b0, 1'b0);
        push_a(8'h22, 2, 1'b0, 1'b1);
        push_a(8'h11, 3, 1'b1, 1'b1);
        offer_a(32'h1122_3344, 3'd4, w);
        a_in_valid = 1'b0;
        @(posedge HCLK); #1;
        a_out_ready = 1'b0;
        a_in_valid  = 1'b1;
        a_in_data   = 32'h9999_9999;
        repeat (3) begin
            @(negedge HCLK);
            check("stall.data",     32'(a_out_data), 32'h33);
            check("stall.idx",      32'(a_out_idx),  32'd1);
            check("stall.last",     32'(a_out_last), 32'd0);
            check("stall.in_ready", 32'(a_in_ready), 32'd0);
            @(posedge HCLK); #1;
        end
        a_in_valid  = 1'b0;
        a_out_ready = 1'b1;
        repeat (4) @(posedge HCLK);
        #1;

        // Back-to-back words with in_valid held; second is taken on word 1's last beat.
        push_a(8'h04, 0, 1'b0, 1'b0);
        push_a(8'h03, 1, 1'b0, 1'b1);
        push_a(8'h02, 2, 1'b0, 1'b1);
        push_a(8'h01, 3, 1'b1, 1'b1);
        push_a(8'h08, 0, 1'b0, 1'b1);
        push_a(8'h07, 1, 1'b0, 1'b1);
        push_a(8'h06, 2, 1'b0, 1'b1);
        push_a(8'h05, 3, 1'b1, 1'b1);
        offer_a(32'h0102_0304, 3'd0, w);
        check("b2b.first_wait", 32'(w), 32'd1);
        offer_a(32'h0506_0708, 3'd0, w);
        check("b2b.second_wait", 32'(w), 32'd4);
        a_in_valid = 1'b0;
        repeat (5) @(posedge HCLK);
        #1;

        // Single-beat words at one word per cycle.
        push_a(8'h55, 0, 1'b1, 1'b0);
        push_a(8'h66, 0, 1'b1, 1'b1);
        push_a(8'h77, 0, 1'b1, 1'b1);
        offer_a(32'hABCD_0055, 3'd1, w);
        offer_a(32'h1234_0066, 3'd1, w);
        check("short.wait2", 32'(w), 32'd1);
        offer_a(32'h5A5A_0077, 3'd1, w);
        check("short.wait3", 32'(w), 32'd1);
        a_in_valid = 1'b0;
        repeat (2) @(posedge HCLK);
        #1;

        // Reset during beat 2 of DEADBEEF: AD and DE must never appear.
        push_a(8'hEF, 0, 1'b0, 1'b0);
        push_a(8'hBE, 1, 1'b0, 1'b1);
        offer_a(32'hDEAD_BEEF, 3'd0, w);
        a_in_valid = 1'b0;
        @(posedge HCLK); #1;
        @(posedge HCLK); #1;
        HRESET = 1'b1;
        @(negedge HCLK);
        check("rstmid.beat2_data", 32'(a_out_data), 32'hAD);
        check("rstmid.in_ready",   32'(a_in_ready), 32'd0);
        @(posedge HCLK); #1;
        check("rstmid.out_valid", 32'(a_out_valid), 32'd0);
        check("rstmid.out_data",  32'(a_out_data),  32'd0);
        check("rstmid.busy",      32'(a_busy),      32'd0);
        HRESET = 1'b0;
        #1;
        check("rstmid.release_in_ready", 32'(a_in_ready), 32'd1);
        push_a(8'h78, 0, 1'b0, 1'b0);
        push_a(8'h56, 1, 1'b0, 1'b1);
        push_a(8'h34, 2, 1'b0, 1'b1);
        push_a(8'h12, 3, 1'b1, 1'b1);
        offer_a(32'h1234_5678, 3'd0, w);
        a_in_valid = 1'b0;
        check("rstmid.restart_idx", 32'(a_out_idx), 32'd0);
        repeat (6) @(posedge HCLK);
        #1;

        check("end.A.queue_drained", 32'(qa.size()), 32'd0);
        check("end.B.queue_drained", 32'(qb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
